// File: rtl/cfg_req_timeout_tracker.sv
// Timeout tracker for the root-port config-space Avalon-MM path: ages in-order requests and
// answers over-age ones with an error completion. Optional interrupt: CFG_REQ_TIMEOUT_IRQ_EN.
module cfg_req_timeout_tracker #(
  parameter int                    ADDR_WIDTH      = 14,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    RESP_WIDTH      = 2,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter int                    TIMER_WIDTH     = 32,
  parameter int                    TIMEOUT_DEFAULT = 5000000,
  parameter logic [RESP_WIDTH-1:0] SLAVE_ERROR     = 2'b10,
  parameter int                    CSR_ADDR_WIDTH  = 8,
  parameter int                    CSR_DATA_WIDTH  = 32
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      host_read_i,
  input  logic                      host_write_i,
  input  logic [ADDR_WIDTH-1:0]     host_address_i,
  input  logic [DATA_WIDTH-1:0]     host_writedata_i,
  output logic                      host_waitrequest_o,
  output logic                      host_readdatavalid_o,
  output logic                      host_writerespvalid_o,
  output logic [DATA_WIDTH-1:0]     host_readdata_o,
  output logic [RESP_WIDTH-1:0]     host_resp_o,
  output logic                      cs_read_o,
  output logic                      cs_write_o,
  output logic [ADDR_WIDTH-1:0]     cs_address_o,
  output logic [DATA_WIDTH-1:0]     cs_writedata_o,
  input  logic                      cs_waitrequest_i,
  input  logic                      cs_readdatavalid_i,
  input  logic                      cs_writerespvalid_i,
  input  logic [DATA_WIDTH-1:0]     cs_readdata_i,
  input  logic [RESP_WIDTH-1:0]     cs_resp_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_address_i,
  input  logic                      csr_read_i,
  input  logic                      csr_write_i,
  input  logic [CSR_DATA_WIDTH-1:0] csr_writedata_i,
  output logic [CSR_DATA_WIDTH-1:0] csr_readdata_o,
  output logic                      csr_readdatavalid_o,
  output logic                      csr_waitrequest_o,
  output logic                      irq_o
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_TIMEOUT = CSR_ADDR_WIDTH'(8'h00);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_STATUS  = CSR_ADDR_WIDTH'(8'h04);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_TOCNT   = CSR_ADDR_WIDTH'(8'h08);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_OCC     = CSR_ADDR_WIDTH'(8'h0C);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Tracking FIFO: one timestamp and one is_write flag per in-flight request
  logic [TIMER_WIDTH-1:0]     fifo_ts_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] fifo_wr_q;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           outstanding_q, outstanding_d, stale_q, stale_d;
  logic [TIMER_WIDTH-1:0]     now_q, timeout_q, timeout_d, age;
  logic                       status_to_q, status_to_d;
  logic [15:0]                to_count_q, to_count_d;
  logic                       irq_en;

  logic                       rdv_q, rdv_d, wrv_q, wrv_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0]      resp_q, resp_d;
  logic [CSR_DATA_WIDTH-1:0]  csr_rdata_q, csr_rdata_d;
  logic                       csr_rdv_q;

  logic [CNT_W:0] occ_sum;
  logic           full, accept, rsp_valid, drop, fwd, expire, pop, head_is_write;

`ifdef CFG_REQ_TIMEOUT_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;
  assign irq_en = irq_en_q;
  assign irq_o  = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

  assign occ_sum            = {1'b0, outstanding_q} + {1'b0, stale_q};
  assign full               = (occ_sum == (CNT_W + 1)'(MAX_OUTSTANDING));
  assign cs_read_o          = host_read_i & ~full;
  assign cs_write_o         = host_write_i & ~full;
  assign cs_address_o       = host_address_i;
  assign cs_writedata_o     = host_writedata_i;
  assign host_waitrequest_o = cs_waitrequest_i | full;
  assign accept             = (cs_read_o | cs_write_o) & ~cs_waitrequest_i;

  // A real response always belongs to the oldest request; while stale entries remain,
  // the oldest one is an already-terminated request whose late answer must be swallowed.
  assign rsp_valid     = cs_readdatavalid_i | cs_writerespvalid_i;
  assign drop          = rsp_valid & (stale_q != '0);
  assign fwd           = rsp_valid & (stale_q == '0);
  assign head_is_write = fifo_wr_q[rd_ptr_q];
  assign age           = now_q - fifo_ts_q[rd_ptr_q];
  assign expire        = (outstanding_q != '0) & (timeout_q != '0) & (age >= timeout_q) & ~rsp_valid;
  assign pop           = expire | (fwd & (outstanding_q != '0));

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(pop);
    stale_d       = stale_q + CNT_W'(expire) - CNT_W'(drop);
  end

  always_comb begin
    rdv_d   = 1'b0;
    wrv_d   = 1'b0;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    if (fwd) begin
      rdv_d   = cs_readdatavalid_i;
      wrv_d   = cs_writerespvalid_i;
      rdata_d = cs_readdata_i;
      resp_d  = cs_resp_i;
    end else if (expire) begin
      rdv_d   = ~head_is_write;
      wrv_d   = head_is_write;
      rdata_d = head_is_write ? '0 : '1;
      resp_d  = SLAVE_ERROR;
    end
  end

  // CSR writes: a timeout in the same cycle as W1C keeps TO set; a TO_COUNT write wins over increment
  always_comb begin
    timeout_d   = timeout_q;
    status_to_d = status_to_q;
    to_count_d  = expire ? sat_inc16(to_count_q) : to_count_q;
`ifdef CFG_REQ_TIMEOUT_IRQ_EN
    irq_en_d    = irq_en_q;
`endif
    if (csr_write_i) begin
      case (csr_address_i)
        CSR_TIMEOUT: timeout_d = TIMER_WIDTH'(csr_writedata_i);
        CSR_STATUS: begin
          if (csr_writedata_i[0]) status_to_d = 1'b0;
`ifdef CFG_REQ_TIMEOUT_IRQ_EN
          irq_en_d = csr_writedata_i[1];
`endif
        end
        CSR_TOCNT: to_count_d = '0;
        default: ;
      endcase
    end
    if (expire) status_to_d = 1'b1;
  end

  always_comb begin
    csr_rdata_d = '0;
    if (csr_read_i) begin
      case (csr_address_i)
        CSR_TIMEOUT: csr_rdata_d = CSR_DATA_WIDTH'(timeout_q);
        CSR_STATUS:  csr_rdata_d = CSR_DATA_WIDTH'({irq_en, status_to_q});
        CSR_TOCNT:   csr_rdata_d = CSR_DATA_WIDTH'(to_count_q);
        CSR_OCC:     csr_rdata_d = CSR_DATA_WIDTH'({8'(stale_q), 8'(outstanding_q)});
        default:     csr_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_ts_q[i] <= '0;
      fifo_wr_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      stale_q       <= '0;
      now_q         <= '0;
      timeout_q     <= TIMER_WIDTH'(TIMEOUT_DEFAULT);
      status_to_q   <= 1'b0;
      to_count_q    <= '0;
      rdv_q         <= 1'b0;
      wrv_q         <= 1'b0;
      rdata_q       <= '0;
      resp_q        <= '0;
      csr_rdata_q   <= '0;
      csr_rdv_q     <= 1'b0;
    end else begin
      if (accept) begin
        fifo_ts_q[wr_ptr_q] <= now_q;
        fifo_wr_q[wr_ptr_q] <= host_write_i;
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      now_q         <= now_q + 1'b1;
      timeout_q     <= timeout_d;
      status_to_q   <= status_to_d;
      to_count_q    <= to_count_d;
      rdv_q         <= rdv_d;
      wrv_q         <= wrv_d;
      rdata_q       <= rdata_d;
      resp_q        <= resp_d;
      csr_rdata_q   <= csr_rdata_d;
      csr_rdv_q     <= csr_read_i;
    end
  end

`ifdef CFG_REQ_TIMEOUT_IRQ_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= status_to_q & irq_en_q;
    end
  end
`endif

  assign host_readdatavalid_o  = rdv_q;
  assign host_writerespvalid_o = wrv_q;
  assign host_readdata_o       = rdata_q;
  assign host_resp_o           = resp_q;
  assign csr_readdata_o        = csr_rdata_q;
  assign csr_readdatavalid_o   = csr_rdv_q;
  assign csr_waitrequest_o     = 1'b0;

endmodule
